// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port word RAM behind a simple cs/we request interface.
// After reset the controller sweeps every address to zero (busy high),
// then serves one request per cycle. Reads return data one cycle later.
//
// Optional feature macro: RAM_PARITY_EN
//   Adds one even-parity bit per stored word, an error-injection input and
//   a parity-error output that is qualified by rvalid.
//
// Ports:
//   clk      in   clock, all state on rising edge
//   reset    in   synchronous active-high reset
//   cs       in   request valid
//   we       in   1 = write, 0 = read
//   addr     in   [ADDR_W] word address
//   wdata    in   [DATA_W] write data
//   inj_err  in   (RAM_PARITY_EN) invert stored parity bit on write
//   perr     out  (RAM_PARITY_EN) parity mismatch of read word, with rvalid
//   rdata    out  [DATA_W] registered read data, held between reads
//   rvalid   out  one-cycle pulse per accepted read
//   busy     out  high while the clear sweep runs
//   wr_cnt   out  [16] saturating count of accepted writes
module ram_ctrl #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef RAM_PARITY_EN
  input  logic              inj_err,
  output logic              perr,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic [15:0]       wr_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_busy;
  logic [15:0]       r_wr_cnt;
  logic [MEM_W-1:0]  r_mem [DEPTH];
`ifdef RAM_PARITY_EN
  logic              r_perr;
`endif

  logic              w_req;
  logic              w_wr;
  logic              w_rd;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [MEM_W-1:0]  w_mem_data;
  logic [MEM_W-1:0]  w_rd_word;

  // Requests are only honoured in IDLE; anything seen during the sweep is dropped.
  assign w_req = cs & (r_state == ST_IDLE);
  assign w_wr  = w_req & we;
  assign w_rd  = w_req & ~we;

  // Memory port is shared between the clear sweep and host writes.
  assign w_mem_we   = ~reset & ((r_state == ST_CLEAR) | w_wr);
  assign w_mem_addr = (r_state == ST_CLEAR) ? r_ptr : addr;
`ifdef RAM_PARITY_EN
  // Even parity: stored bit makes total ones even; inj_err flips it.
  assign w_mem_data = (r_state == ST_CLEAR) ? '0 : {(^wdata) ^ inj_err, wdata};
`else
  assign w_mem_data = (r_state == ST_CLEAR) ? '0 : wdata;
`endif
  assign w_rd_word  = r_mem[addr];

  // Storage array, no reset: the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_CLEAR;
      r_ptr    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b1;
      r_wr_cnt <= '0;
`ifdef RAM_PARITY_EN
      r_perr   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rvalid <= 1'b0;
`ifdef RAM_PARITY_EN
          r_perr   <= 1'b0;
`endif
          r_ptr    <= r_ptr + ADDR_W'(1);
          // Leave CLEAR once the last address has been zeroed.
          if (&r_ptr) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          r_rvalid <= w_rd;
          if (w_rd) begin
            r_rdata <= w_rd_word[DATA_W-1:0];
          end
`ifdef RAM_PARITY_EN
          r_perr <= w_rd & (^w_rd_word);
`endif
          if (w_wr && (r_wr_cnt != 16'hFFFF)) begin
            r_wr_cnt <= r_wr_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;
  assign wr_cnt = r_wr_cnt;
`ifdef RAM_PARITY_EN
  assign perr   = r_perr;
`endif

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 4, word width in bits (1..32).
REQ-002 SHALL have parameter ADDR_W, default 12, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cs  input  1  chip select; request valid when high.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled only with cs.
REQ-007 SHALL have port addr  input  ADDR_W  word address.
REQ-008 SHALL have port wdata  input  DATA_W  write data.
REQ-009 SHALL have port rdata  output  DATA_W  registered read data.
REQ-010 SHALL have port rvalid  output  1  one-cycle pulse, rdata valid this cycle.
REQ-011 SHALL have port busy  output  1  high while clear sequence runs; requests ignored.
REQ-012 SHALL have port wr_cnt  output  16  count of accepted writes, saturating at 16'hFFFF.

Function
REQ-013 SHALL implement FSM states CLEAR and IDLE; reset enters CLEAR with clear pointer = 0.
REQ-014 In CLEAR SHALL write 0 to word[pointer] each cycle, increment pointer, and enter IDLE after address DEPTH-1 is written (busy high exactly DEPTH cycles after reset release).
REQ-015 SHALL accept a request only in IDLE when cs=1; requests in CLEAR are dropped, not queued.
REQ-016 Accepted write SHALL update word[addr] at that edge; rvalid stays 0.
REQ-017 Accepted read SHALL drive rdata = word[addr] and rvalid = 1 in the next cycle (latency 1).
REQ-018 rdata SHALL hold its last value until the next accepted read; rvalid SHALL be 1 for exactly one cycle per read.
REQ-019 Back-to-back reads SHALL sustain one read per cycle with rvalid continuously high.
REQ-020 Read of an address written in the previous cycle SHALL return the new data.
REQ-021 wr_cnt SHALL increment by 1 per accepted write and stop at 16'hFFFF (no wrap).
REQ-022 addr SHALL wrap naturally within ADDR_W bits; no out-of-range condition exists.

Reset
REQ-023 reset high at any edge SHALL force: state CLEAR, pointer 0, rdata 0, rvalid 0, busy 1, wr_cnt 0.
REQ-024 reset asserted mid-CLEAR or mid-operation SHALL restart the clear sequence from address 0; a request present in the same cycle SHALL be dropped.

Configuration
REQ-025 Macro RAM_PARITY_EN defined SHALL add one even-parity bit per stored word, input inj_err (1 bit, inverts the stored parity bit on a write), and output perr (1 bit).
REQ-026 With RAM_PARITY_EN, perr SHALL equal parity mismatch of the read word, valid with rvalid, 0 otherwise and 0 after reset; CLEAR writes correct parity.
REQ-027 Without RAM_PARITY_EN, inj_err and perr SHALL not exist and storage SHALL be DATA_W bits per word.

Verification (ADDR_W=4, DATA_W=4)
REQ-028 Reset 1 cycle, release -> busy=1 for 16 cycles, then 0; reads of 0x0..0xF return 4'h0 each with rvalid.
REQ-029 Writes 0x0<-A, 0x1<-B, 0x2<-C, then reads 0x0,0x1,0x2 back-to-back -> rdata A,B,C on consecutive cycles, rvalid high 3 cycles, wr_cnt=3.
REQ-030 cs=1 we=1 addr=0x5 wdata=F during busy -> after clear, read 0x5 returns 0, wr_cnt=0.
REQ-031 Write 0x7<-9, read 0x7 next cycle -> rdata=9 one cycle later.
REQ-032 Reset asserted at clear cycle 8 -> busy stays high 16 further cycles after release; rdata=0, rvalid=0.
REQ-033 With RAM_PARITY_EN: write 0x3<-6 with inj_err=1, read 0x3 -> rdata=6, perr=1; rewrite with inj_err=0, read -> perr=0.
